conv_layer_sequencer: RTL

- Layer-level controller for the integer convolution engine (conv_control_integer).
- Runs the engine once per kernel pass: issues conv_start, serves need_pic from the image SRAM, and routes each conv_result to a flat result SRAM at a per-kernel offset.
- Pulses layer_done after the last pass completes.
- Sits between the top-level layer FSM and the engine/SRAM pair.

---
 rtl/conv_seq_pkg.sv | 29 ++
 rtl/conv_seq_result_wr.sv | 46 ++++
 rtl/conv_layer_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and default geometry for the convolution layer sequencer.
// Defaults size a 28x28, 3-channel, 4-kernel layer; the top overrides them via parameters.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam int PIC_SIZE     = 28;
  localparam int CHANNEL      = 3;
  localparam int KERNEL_TOTAL = 4;
  localparam int PLANE        = PIC_SIZE * PIC_SIZE;
  localparam int IMG_WORDS    = CHANNEL * PLANE;

  // Address width that never collapses to zero bits for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PLANE_AW = width_of(PLANE);
  localparam int IMG_AW   = width_of(IMG_WORDS);
  localparam int RES_AW   = width_of(KERNEL_TOTAL * PLANE);

endpackage

// File: rtl/conv_seq_result_wr.sv
// Result writer: registers each engine result into the flat result SRAM at kernel_idx*plane + addr.
// Latency 1 cycle, no backpressure; ReLU clamping on negative results when RESULT_RELU_EN is defined.
module conv_seq_result_wr
  import conv_seq_pkg::*;
#(
  parameter int pic_size         = PIC_SIZE,
  parameter int kernel_total     = KERNEL_TOTAL,
  parameter int conv_result_bits = 11
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [width_of(kernel_total)-1:0]             kernel_idx,
  input  logic                                          conv_result_valid,
  input  logic [conv_result_bits-1:0]                   conv_result,
  input  logic [width_of(pic_size*pic_size)-1:0]        conv_result_addr,
  output logic                                          res_wr_en,
  output logic [width_of(kernel_total*pic_size*pic_size)-1:0] res_wr_addr,
  output logic [conv_result_bits-1:0]                   res_wr_data
);

  localparam int PLANE_SZ = pic_size * pic_size;
  localparam int RW       = width_of(kernel_total * PLANE_SZ);

  logic [conv_result_bits-1:0] data_nxt;

`ifdef RESULT_RELU_EN
  assign data_nxt = conv_result[conv_result_bits-1] ? '0 : conv_result;
`else
  assign data_nxt = conv_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      res_wr_en <= conv_result_valid;
      if (conv_result_valid) begin
        res_wr_addr <= RW'(kernel_idx) * RW'(PLANE_SZ) + RW'(conv_result_addr);
        res_wr_data <= data_nxt;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer controller: runs the conv engine once per kernel, feeds pixels from image SRAM, writes results.
// need_pic to pic_valid 2 cycles, result strobe to SRAM write 1 cycle; need_pic low stalls reads (RESULT_RELU_EN optional).
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int pic_bits         = 2,
  parameter int pic_size         = PIC_SIZE,
  parameter int channel          = CHANNEL,
  parameter int kernel_total     = KERNEL_TOTAL,
  parameter int conv_result_bits = 11
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                layer_start,
  output logic                                                layer_busy,
  output logic                                                layer_done,
  output logic [width_of(kernel_total)-1:0]                   kernel_idx,
  output logic                                                conv_start,
  input  logic                                                need_pic,
  output logic [pic_bits-1:0]                                 pic,
  output logic                                                pic_valid,
  input  logic                                                conv_finish,
  input  logic                                                conv_result_valid,
  input  logic [conv_result_bits-1:0]                         conv_result,
  input  logic [width_of(pic_size*pic_size)-1:0]              conv_result_addr,
  output logic                                                img_rd_en,
  output logic [width_of(channel*pic_size*pic_size)-1:0]      img_rd_addr,
  input  logic [pic_bits-1:0]                                 img_rd_data,
  output logic                                                res_wr_en,
  output logic [width_of(kernel_total*pic_size*pic_size)-1:0] res_wr_addr,
  output logic [conv_result_bits-1:0]                         res_wr_data
);

  localparam int IMG_WORDS_P = channel * pic_size * pic_size;
  localparam int IW          = width_of(IMG_WORDS_P);
  localparam int KW          = width_of(kernel_total);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_START = 3'(START);
  localparam logic [2:0] S_FEED  = 3'(FEED);
  localparam logic [2:0] S_DRAIN = 3'(DRAIN);
  localparam logic [2:0] S_NEXT  = 3'(NEXT);
  localparam logic [2:0] S_DONE  = 3'(DONE);

  logic [2:0] state;
  logic       rd_pend;
  logic       last_rd;
  logic       kill;

  assign img_rd_en  = (state == S_FEED) && need_pic;
  assign last_rd    = (img_rd_addr == IW'(IMG_WORDS_P - 1));
  // An early finish abandons the pass and squashes whatever read is still returning.
  assign kill       = (state == S_FEED) && conv_finish;
  assign conv_start = (state == S_START) || (state == S_FEED) || (state == S_DRAIN);
  assign layer_busy = (state != S_IDLE) && (state != S_DONE);
  assign layer_done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      kernel_idx  <= '0;
      img_rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (layer_start) begin
          state       <= S_START;
          kernel_idx  <= '0;
          img_rd_addr <= '0;
        end
        S_START: state <= S_FEED;
        S_FEED: begin
          if (conv_finish) begin
            state <= S_NEXT;
          end else if (img_rd_en) begin
            img_rd_addr <= img_rd_addr + 1'b1;
            if (last_rd) state <= S_DRAIN;
          end
        end
        S_DRAIN: if (conv_finish) state <= S_NEXT;
        S_NEXT: begin
          if (kernel_idx == KW'(kernel_total - 1)) begin
            state <= S_DONE;
          end else begin
            kernel_idx  <= kernel_idx + 1'b1;
            img_rd_addr <= '0;
            state       <= S_START;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      pic_valid <= 1'b0;
      pic       <= '0;
    end else begin
      rd_pend   <= img_rd_en && !kill;
      pic_valid <= rd_pend && !kill;
      pic       <= (rd_pend && !kill) ? img_rd_data : '0;
    end
  end

  conv_seq_result_wr #(
    .pic_size         (pic_size),
    .kernel_total     (kernel_total),
    .conv_result_bits (conv_result_bits)
  ) u_result_wr (
    .clk               (clk),
    .rst_n             (rst_n),
    .kernel_idx        (kernel_idx),
    .conv_result_valid (conv_result_valid),
    .conv_result       (conv_result),
    .conv_result_addr  (conv_result_addr),
    .res_wr_en         (res_wr_en),
    .res_wr_addr       (res_wr_addr),
    .res_wr_data       (res_wr_data)
  );

endmodule
